// File: rtl/npu_tile_sequencer.sv
// NPU tile sequencer: MMIO register file, A/W buffer write-address generator and tiled OS/INTRA FSM.
// Optional feature: define NPU_PERF_CNT_EN to add the PERF busy-cycle counter at offset 0x2C.
module npu_tile_sequencer #(
    parameter int DWIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ARRAY_N = 16,
    parameter int ARRAY_M = 16,
    parameter int KMAX = 1024,
    parameter logic [ADDR_WIDTH-1:0] PARA_BASE = 32'h4000_0000,
    parameter logic [ADDR_WIDTH-1:0] IMEM_BASE = 32'h4001_0000,
    parameter logic [ADDR_WIDTH-1:0] WMEM_BASE = 32'h4002_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cen_i,
    input  logic                  wen_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0]     wdata_i,
    output logic [DWIDTH-1:0]     rdata_o,
    output logic                  rvalid_o,
    output logic [ARRAY_N-1:0]    a_ram_w_en,
    output logic [ADDR_WIDTH-1:0] a_ram_w_addr,
    output logic [DWIDTH-1:0]     a_ram_w_data,
    output logic [ARRAY_M-1:0]    w_ram_w_en,
    output logic [ADDR_WIDTH-1:0] w_ram_w_addr,
    output logic [DWIDTH-1:0]     w_ram_w_data,
    output logic                  a_buf_on,
    output logic                  w_buf_on,
    output logic [ADDR_WIDTH-1:0] a_base_addr,
    output logic [ADDR_WIDTH-1:0] w_base_addr,
    output logic [ADDR_WIDTH-1:0] o_base_addr,
    output logic [2:0]            operation_signal_in,
    output logic                  sa_reset,
    output logic                  o_ag_o_on,
    output logic                  Intranet_on,
    output logic                  Intra_sig_start,
    output logic                  irq_o
);
    localparam int KW = (KMAX > 1) ? $clog2(KMAX) : 1;
    localparam int RW = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;
    localparam int CW = (ARRAY_M > 1) ? $clog2(ARRAY_M) : 1;
    localparam logic [DWIDTH-1:0] DW1 = DWIDTH'(1'b1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FLOW = 3'd1, S_SKEW = 3'd2, S_DRAIN = 3'd3,
        S_STORE = 3'd4, S_NEXT = 3'd5, S_INTRA = 3'd6, S_DONE = 3'd7
    } state_e;

    state_e state_q, state_d;
    logic [DWIDTH-1:0] cnt_q, cnt_d, tile_q, tile_d, dur_s;
    logic [DWIDTH-1:0] reg_a_base_q, reg_rows_q, reg_w_base_q, reg_cols_q, reg_o_base_q;
    logic [DWIDTH-1:0] reg_intra_o_q, reg_intra_a_q, reg_k_q, reg_tiles_q;
    logic [ADDR_WIDTH-1:0] a_base_q, w_base_q, o_base_q;
    logic [RW-1:0] a_row_q;
    logic [KW-1:0] a_col_q, w_col_q;
    logic [CW-1:0] w_row_q;
    logic [DWIDTH-1:0] rdata_q, rdata_d, perf_s;
    logic rvalid_q, done_q, err_q;
    logic a_on_q, w_on_q, sar_q, oag_q, inet_q, istart_q, irq_q;
    logic a_on_d, w_on_d, sar_d, oag_d, inet_d, istart_d, irq_d;
    logic [2:0] op_q, op_d;

    logic [15:0] offs_s;
    logic in_para_s, in_imem_s, in_wmem_s, wr_s, rd_s, busy_s, reg_wr_s, k_wr_s, ctrl_wr_s;
    logic start_os_s, start_in_s, start_req_s, cfg_bad_s, reject_s, go_s;
    logic a_wr_s, w_wr_s, last_s, last_tile_s;

    assign offs_s      = addr_i[15:0];
    assign in_para_s   = (addr_i[ADDR_WIDTH-1:16] == PARA_BASE[ADDR_WIDTH-1:16]);
    assign in_imem_s   = (addr_i[ADDR_WIDTH-1:16] == IMEM_BASE[ADDR_WIDTH-1:16]);
    assign in_wmem_s   = (addr_i[ADDR_WIDTH-1:16] == WMEM_BASE[ADDR_WIDTH-1:16]);
    assign wr_s        = cen_i & wen_i;
    assign rd_s        = cen_i & ~wen_i;
    assign busy_s      = (state_q != S_IDLE);
    assign reg_wr_s    = wr_s & in_para_s & ~busy_s;
    assign k_wr_s      = reg_wr_s & (offs_s == 16'h0024);
    assign ctrl_wr_s   = wr_s & in_para_s & (offs_s == 16'h0000);
    assign start_os_s  = ctrl_wr_s & (wdata_i == DWIDTH'(2'd1));
    assign start_in_s  = ctrl_wr_s & (wdata_i == DWIDTH'(2'd2));
    assign start_req_s = (start_os_s | start_in_s) & ~busy_s;
    assign cfg_bad_s   = (reg_k_q == '0) || (reg_k_q > DWIDTH'(KMAX)) || (reg_tiles_q == '0) ||
                         (reg_rows_q == '0) || (reg_rows_q > DWIDTH'(ARRAY_N)) ||
                         (reg_cols_q == '0) || (reg_cols_q > DWIDTH'(ARRAY_M));
    assign reject_s    = start_req_s & cfg_bad_s;
    assign go_s        = start_req_s & ~cfg_bad_s;

    // Buffer write ports are combinational; placement follows write order, not the bus address.
    assign a_wr_s       = wr_s & in_imem_s & ~busy_s;
    assign w_wr_s       = wr_s & in_wmem_s & ~busy_s;
    assign a_ram_w_en   = a_wr_s ? (ARRAY_N'(1'b1) << a_row_q) : '0;
    assign w_ram_w_en   = w_wr_s ? (ARRAY_M'(1'b1) << w_row_q) : '0;
    assign a_ram_w_addr = ADDR_WIDTH'(reg_a_base_q) + ADDR_WIDTH'(a_col_q);
    assign w_ram_w_addr = ADDR_WIDTH'(reg_w_base_q) + ADDR_WIDTH'(w_col_q);
    assign a_ram_w_data = wdata_i;
    assign w_ram_w_data = wdata_i;

    // A-buffer placement counters
    always_ff @(posedge clk_i) begin
        if (rst_i || k_wr_s || go_s) begin
            a_row_q <= '0;
            a_col_q <= '0;
        end else if (a_wr_s) begin
            if (DWIDTH'(a_col_q) == reg_k_q - DW1) begin
                a_col_q <= '0;
                a_row_q <= (DWIDTH'(a_row_q) == reg_rows_q - DW1) ? '0 : a_row_q + RW'(1'b1);
            end else begin
                a_col_q <= a_col_q + KW'(1'b1);
            end
        end
    end

    // W-buffer placement counters
    always_ff @(posedge clk_i) begin
        if (rst_i || k_wr_s || go_s) begin
            w_row_q <= '0;
            w_col_q <= '0;
        end else if (w_wr_s) begin
            if (DWIDTH'(w_col_q) == reg_k_q - DW1) begin
                w_col_q <= '0;
                w_row_q <= (DWIDTH'(w_row_q) == reg_cols_q - DW1) ? '0 : w_row_q + CW'(1'b1);
            end else begin
                w_col_q <= w_col_q + KW'(1'b1);
            end
        end
    end

    // Configuration register file
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_a_base_q  <= '0; reg_rows_q    <= '0; reg_w_base_q <= '0;
            reg_cols_q    <= '0; reg_o_base_q  <= '0; reg_intra_o_q <= '0;
            reg_intra_a_q <= '0; reg_k_q       <= '0; reg_tiles_q  <= '0;
        end else if (reg_wr_s) begin
            case (offs_s)
                16'h0008: reg_a_base_q  <= wdata_i;
                16'h000C: reg_rows_q    <= wdata_i;
                16'h0010: reg_w_base_q  <= wdata_i;
                16'h0014: reg_cols_q    <= wdata_i;
                16'h0018: reg_o_base_q  <= wdata_i;
                16'h001C: reg_intra_o_q <= wdata_i;
                16'h0020: reg_intra_a_q <= wdata_i;
                16'h0024: reg_k_q       <= wdata_i;
                16'h0028: reg_tiles_q   <= wdata_i;
                default:  reg_k_q       <= reg_k_q;
            endcase
        end
    end

`ifdef NPU_PERF_CNT_EN
    logic [31:0] perf_q;
    // Busy-cycle counter, restarted by each accepted start and saturating
    always_ff @(posedge clk_i) begin
        if (rst_i || go_s) begin
            perf_q <= 32'd0;
        end else if (busy_s && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end
    assign perf_s = DWIDTH'(perf_q);
`else
    assign perf_s = '0;
`endif

    // Read-data mux; IMEM/WMEM and unmapped offsets read as zero
    always_comb begin
        rdata_d = '0;
        if (rd_s && in_para_s) begin
            case (offs_s)
                16'h0004: rdata_d = {{(DWIDTH-3){1'b0}}, err_q, done_q, busy_s};
                16'h0008: rdata_d = reg_a_base_q;
                16'h000C: rdata_d = reg_rows_q;
                16'h0010: rdata_d = reg_w_base_q;
                16'h0014: rdata_d = reg_cols_q;
                16'h0018: rdata_d = reg_o_base_q;
                16'h001C: rdata_d = reg_intra_o_q;
                16'h0020: rdata_d = reg_intra_a_q;
                16'h0024: rdata_d = reg_k_q;
                16'h0028: rdata_d = reg_tiles_q;
                16'h002C: rdata_d = perf_s;
                default:  rdata_d = '0;
            endcase
        end else begin
            rdata_d = '0;
        end
    end

    // Phase length of the current state; cnt runs 0..dur-1
    always_comb begin
        case (state_q)
            S_FLOW:  dur_s = reg_k_q;
            S_SKEW:  dur_s = reg_rows_q + reg_cols_q - DW1;
            S_DRAIN: dur_s = DWIDTH'(ARRAY_N) - reg_rows_q;
            S_STORE: dur_s = reg_rows_q + DW1;
            S_INTRA: dur_s = reg_rows_q + reg_cols_q;
            default: dur_s = DW1;
        endcase
    end
    assign last_s      = (cnt_q == dur_s - DW1);
    assign last_tile_s = (tile_q == reg_tiles_q - DW1);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + DW1;
        tile_d  = tile_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (go_s) begin
                    tile_d  = '0;
                    state_d = start_os_s ? S_FLOW : S_INTRA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FLOW:  if (last_s) begin state_d = S_SKEW; cnt_d = '0; end else state_d = S_FLOW;
            S_SKEW: begin
                if (last_s) begin
                    state_d = (reg_rows_q == DWIDTH'(ARRAY_N)) ? S_STORE : S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    state_d = S_SKEW;
                end
            end
            S_DRAIN: if (last_s) begin state_d = S_STORE; cnt_d = '0; end else state_d = S_DRAIN;
            S_STORE: if (last_s) begin state_d = S_NEXT; cnt_d = '0; end else state_d = S_STORE;
            S_NEXT: begin
                cnt_d = '0;
                if (last_tile_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FLOW;
                    tile_d  = tile_q + DW1;
                end
            end
            S_INTRA: if (last_s) begin state_d = S_DONE; cnt_d = '0; end else state_d = S_INTRA;
            S_DONE:  begin state_d = S_IDLE; cnt_d = '0; end
            default: begin state_d = S_IDLE; cnt_d = '0; end
        endcase
    end

    // Control decode from the next state so the registered outputs line up with state_q
    always_comb begin
        a_on_d = 1'b0; w_on_d = 1'b0; op_d = 3'b000; sar_d = 1'b0;
        oag_d = 1'b0; inet_d = 1'b0; istart_d = 1'b0;
        case (state_d)
            S_IDLE:  sar_d = 1'b1;
            S_FLOW:  begin a_on_d = 1'b1; w_on_d = 1'b1; op_d = 3'b100; end
            S_SKEW:  op_d = 3'b100;
            S_DRAIN: op_d = 3'b110;
            S_STORE: begin op_d = 3'b110; oag_d = 1'b1; end
            S_NEXT:  sar_d = 1'b1;
            S_INTRA: begin inet_d = 1'b1; istart_d = (cnt_d == '0); end
            default: sar_d = 1'b0;
        endcase
        irq_d = (state_d == S_DONE) | reject_s;
    end

    // FSM state, counters and registered control outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE; cnt_q <= '0; tile_q <= '0;
            a_on_q <= 1'b0; w_on_q <= 1'b0; op_q <= 3'b000; sar_q <= 1'b1;
            oag_q <= 1'b0; inet_q <= 1'b0; istart_q <= 1'b0; irq_q <= 1'b0;
            rdata_q <= '0; rvalid_q <= 1'b0;
        end else begin
            state_q <= state_d; cnt_q <= cnt_d; tile_q <= tile_d;
            a_on_q <= a_on_d; w_on_q <= w_on_d; op_q <= op_d; sar_q <= sar_d;
            oag_q <= oag_d; inet_q <= inet_d; istart_q <= istart_d; irq_q <= irq_d;
            rdata_q <= rdata_d; rvalid_q <= rd_s;
        end
    end

    // Tile base addresses and sticky status; a CTRL write clears done/err unless re-set this cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_base_q <= '0; w_base_q <= '0; o_base_q <= '0;
            done_q <= 1'b0; err_q <= 1'b0;
        end else begin
            if (go_s) begin
                a_base_q <= ADDR_WIDTH'(reg_a_base_q);
                w_base_q <= ADDR_WIDTH'(reg_w_base_q);
                o_base_q <= ADDR_WIDTH'(reg_o_base_q);
            end else if ((state_q == S_NEXT) && !last_tile_s) begin
                a_base_q <= a_base_q + ADDR_WIDTH'(reg_k_q);
                o_base_q <= o_base_q + ADDR_WIDTH'(reg_rows_q);
            end
            if (ctrl_wr_s) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (state_d == S_DONE) done_q <= 1'b1;
            if (reject_s) err_q <= 1'b1;
        end
    end

    assign rdata_o             = rdata_q;
    assign rvalid_o            = rvalid_q;
    assign a_buf_on            = a_on_q;
    assign w_buf_on            = w_on_q;
    assign operation_signal_in = op_q;
    assign sa_reset            = sar_q;
    assign o_ag_o_on           = oag_q;
    assign Intranet_on         = inet_q;
    assign Intra_sig_start     = istart_q;
    assign irq_o               = irq_q;
    assign a_base_addr         = a_base_q;
    assign w_base_addr         = w_base_q;
    assign o_base_addr         = o_base_q;
endmodule

// File: tb/tb_npu_tile_sequencer.sv
// Randomized self-checking bench for npu_tile_sequencer against a phase-list reference model.
module tb_npu_tile_sequencer;
    localparam int N = 16;
    localparam int M = 16;
    localparam logic [31:0] PARA = 32'h4000_0000;
    localparam logic [31:0] IMEM = 32'h4001_0000;
    localparam logic [31:0] WMEM = 32'h4002_0000;
    localparam logic [31:0] R_CTRL = PARA + 32'h00, R_STAT = PARA + 32'h04, R_ABASE = PARA + 32'h08;
    localparam logic [31:0] R_ROWS = PARA + 32'h0C, R_WBASE = PARA + 32'h10, R_COLS = PARA + 32'h14;
    localparam logic [31:0] R_OBASE = PARA + 32'h18, R_K = PARA + 32'h24, R_TILES = PARA + 32'h28;
    localparam logic [31:0] R_PERF = PARA + 32'h2C;
    // ctl vector: {a_buf_on, w_buf_on, op[2:0], sa_reset, o_ag_o_on, Intranet_on, Intra_sig_start, irq_o}
    localparam logic [9:0] C_FLOW  = 10'b11_100_00000;
    localparam logic [9:0] C_SKEW  = 10'b00_100_00000;
    localparam logic [9:0] C_DRAIN = 10'b00_110_00000;
    localparam logic [9:0] C_STORE = 10'b00_110_01000;
    localparam logic [9:0] C_SAR   = 10'b00_000_10000;
    localparam logic [9:0] C_DONE  = 10'b00_000_00001;
    localparam logic [9:0] C_INS   = 10'b00_000_00110;
    localparam logic [9:0] C_IN    = 10'b00_000_00100;
    localparam logic [9:0] C_IRQ   = 10'b00_000_10001;

    typedef struct packed {
        logic [9:0]  ctl;
        logic [31:0] ab;
        logic [31:0] wb;
        logic [31:0] ob;
    } rec_t;

    logic clk = 1'b0;
    logic rst, cen, wen;
    logic [31:0] addr, wdata, rdata, a_addr, a_data, w_addr, w_data, ab, wb, ob;
    logic rvalid, a_on, w_on, sar, oag, inet, istart, irq;
    logic [N-1:0] a_en;
    logic [M-1:0] w_en;
    logic [2:0] op;
    wire [9:0] ctl_obs = {a_on, w_on, op, sar, oag, inet, istart, irq};

    int n_pass = 0;
    int n_total = 0;
    rec_t exp_q[$];
    int bad [7][4] = '{'{0, 4, 4, 1}, '{1025, 4, 4, 1}, '{4, 0, 4, 1}, '{4, 17, 4, 1},
                       '{4, 4, 0, 1}, '{4, 4, 17, 1}, '{4, 4, 4, 0}};

    npu_tile_sequencer dut (
        .clk_i(clk), .rst_i(rst), .cen_i(cen), .wen_i(wen), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata), .rvalid_o(rvalid),
        .a_ram_w_en(a_en), .a_ram_w_addr(a_addr), .a_ram_w_data(a_data),
        .w_ram_w_en(w_en), .w_ram_w_addr(w_addr), .w_ram_w_data(w_data),
        .a_buf_on(a_on), .w_buf_on(w_on), .a_base_addr(ab), .w_base_addr(wb), .o_base_addr(ob),
        .operation_signal_in(op), .sa_reset(sar), .o_ag_o_on(oag), .Intranet_on(inet),
        .Intra_sig_start(istart), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        cen = 1'b1; wen = 1'b1; addr = a; wdata = d;
        step();
        cen = 1'b0; wen = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        cen = 1'b1; wen = 1'b0; addr = a;
        step();
        cen = 1'b0;
        check_val("rvalid", {31'd0, rvalid}, 32'd1);
        d = rdata;
    endtask

    task automatic cfg(input int rows, input int cols, input int k, input int tiles,
                       input logic [31:0] a_b, input logic [31:0] w_b, input logic [31:0] o_b);
        bus_wr(R_ABASE, a_b); bus_wr(R_WBASE, w_b); bus_wr(R_OBASE, o_b);
        bus_wr(R_ROWS, 32'(rows)); bus_wr(R_COLS, 32'(cols));
        bus_wr(R_TILES, 32'(tiles)); bus_wr(R_K, 32'(k));
    endtask

    task automatic push_n(input int n, input logic [9:0] c, input logic [31:0] a_b,
                          input logic [31:0] w_b, input logic [31:0] o_b);
        rec_t e;
        e.ctl = c; e.ab = a_b; e.wb = w_b; e.ob = o_b;
        for (int j = 0; j < n; j++) exp_q.push_back(e);
    endtask

    // Buffer fill: write i lands in bank (i/K)%rows at base + i%K
    task automatic fill(input bit is_w, input int k, input int rows, input logic [31:0] base, input int n);
        logic [31:0] d, e_en, e_addr;
        bus_wr(is_w ? R_WBASE : R_ABASE, base);
        bus_wr(is_w ? R_COLS : R_ROWS, 32'(rows));
        bus_wr(R_K, 32'(k));
        for (int i = 0; i < n; i++) begin
            d = $urandom;
            cen = 1'b1; wen = 1'b1; wdata = d;
            addr = (is_w ? WMEM : IMEM) | ($urandom & 32'h0000_FFFC);
            #1;
            e_en = 32'd1 << ((i / k) % rows);
            e_addr = base + 32'(i % k);
            if (is_w) begin
                check_val($sformatf("w_en[%0d]", i), 32'(w_en), e_en);
                check_val($sformatf("w_addr[%0d]", i), w_addr, e_addr);
                check_val("w_data", w_data, d);
                check_val("a_en_idle", 32'(a_en), 32'd0);
            end else begin
                check_val($sformatf("a_en[%0d]", i), 32'(a_en), e_en);
                check_val($sformatf("a_addr[%0d]", i), a_addr, e_addr);
                check_val("a_data", a_data, d);
                check_val("w_en_idle", 32'(w_en), 32'd0);
            end
            step();
            cen = 1'b0; wen = 1'b0;
        end
    endtask

    task automatic compare_run(input bit pokes, input int abort_idx);
        rec_t e;
        logic [31:0] d;
        for (int i = 0; i < exp_q.size(); i++) begin
            e = exp_q[i];
            check_val($sformatf("ctl[%0d]", i), 32'(ctl_obs), 32'(e.ctl));
            check_val($sformatf("a_base[%0d]", i), ab, e.ab);
            check_val($sformatf("w_base[%0d]", i), wb, e.wb);
            check_val($sformatf("o_base[%0d]", i), ob, e.ob);
            if (i == abort_idx) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check_val("abort_ctl", 32'(ctl_obs), 32'(C_SAR));
                check_val("abort_obase", ob, 32'd0);
                bus_rd(R_STAT, d);
                check_val("abort_status", d, 32'd0);
                return;
            end
            if (pokes && i == 5) begin
                check_val("busy_status", rdata, 32'd1);
                check_val("busy_rvalid", {31'd0, rvalid}, 32'd1);
            end
            if (pokes && i == 2) begin
                cen = 1'b1; wen = 1'b1; addr = R_CTRL; wdata = 32'd1;
            end else if (pokes && i == 3) begin
                cen = 1'b1; wen = 1'b1; addr = IMEM + 32'h40; wdata = $urandom;
                #1;
                check_val("busy_a_en", 32'(a_en), 32'd0);
            end else if (pokes && i == 4) begin
                cen = 1'b1; wen = 1'b0; addr = R_STAT;
            end else if (pokes && i == 6) begin
                cen = 1'b1; wen = 1'b1; addr = R_K; wdata = 32'd1;
            end
            step();
            cen = 1'b0; wen = 1'b0;
        end
        bus_rd(R_STAT, d);
        check_val("done_status", d, 32'd2);
        bus_rd(R_PERF, d);
`ifdef NPU_PERF_CNT_EN
        check_val("perf", d, 32'(exp_q.size() - 1));
`else
        check_val("perf", d, 32'd0);
`endif
        bus_wr(R_CTRL, 32'd0);
        bus_rd(R_STAT, d);
        check_val("done_clear", d, 32'd0);
    endtask

    task automatic run_os(input int rows, input int cols, input int k, input int tiles,
                          input logic [31:0] a_b, input logic [31:0] w_b, input logic [31:0] o_b,
                          input bit pokes, input bit abort);
        logic [31:0] ta, to;
        int store_idx;
        exp_q = {};
        store_idx = -1;
        ta = a_b; to = o_b;
        for (int t = 0; t < tiles; t++) begin
            ta = a_b + 32'(k * t);
            to = o_b + 32'(rows * t);
            push_n(k, C_FLOW, ta, w_b, to);
            push_n(rows + cols - 1, C_SKEW, ta, w_b, to);
            if (rows < N) push_n(N - rows, C_DRAIN, ta, w_b, to);
            if (store_idx < 0) store_idx = exp_q.size();
            push_n(rows + 1, C_STORE, ta, w_b, to);
            push_n(1, C_SAR, ta, w_b, to);
        end
        push_n(1, C_DONE, ta, w_b, to);
        push_n(1, C_SAR, ta, w_b, to);
        cfg(rows, cols, k, tiles, a_b, w_b, o_b);
        bus_wr(R_CTRL, 32'd1);
        compare_run(pokes, abort ? store_idx : -1);
    endtask

    task automatic run_intra(input int rows, input int cols,
                             input logic [31:0] a_b, input logic [31:0] w_b, input logic [31:0] o_b);
        exp_q = {};
        push_n(1, C_INS, a_b, w_b, o_b);
        push_n(rows + cols - 1, C_IN, a_b, w_b, o_b);
        push_n(1, C_DONE, a_b, w_b, o_b);
        push_n(1, C_SAR, a_b, w_b, o_b);
        cfg(rows, cols, 1 + $urandom_range(7), 1 + $urandom_range(2), a_b, w_b, o_b);
        bus_wr(R_CTRL, 32'd2);
        compare_run(1'b0, -1);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] vals [9];
        rst = 1'b1; cen = 1'b0; wen = 1'b0; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_ctl", 32'(ctl_obs), 32'(C_SAR));
        check_val("rst_abase", ab, 32'd0);
        check_val("rst_rvalid", {31'd0, rvalid}, 32'd0);
        bus_rd(R_STAT, d);
        check_val("rst_status", d, 32'd0);

        for (int i = 0; i < 9; i++) begin
            vals[i] = $urandom;
            bus_wr(PARA + 32'h08 + 32'(4 * i), vals[i]);
        end
        for (int i = 0; i < 9; i++) begin
            bus_rd(PARA + 32'h08 + 32'(4 * i), d);
            check_val($sformatf("reg_%02h", 8 + 4 * i), d, vals[i]);
        end
        bus_rd(PARA + 32'h30, d); check_val("unmapped", d, 32'd0);
        bus_rd(R_PERF, d);        check_val("perf_rst", d, 32'd0);
        bus_rd(IMEM + 32'h10, d); check_val("imem_rd", d, 32'd0);
        bus_rd(WMEM + 32'h20, d); check_val("wmem_rd", d, 32'd0);

        fill(1'b0, 4, 3, 32'h0000_0000, 13);
        fill(1'b0, $urandom_range(6, 1), $urandom_range(4, 1), $urandom, 20);
        fill(1'b1, $urandom_range(6, 1), $urandom_range(4, 1), 32'hFFFF_FFFE, 20);

        run_os(16, 16, 8, 1, $urandom, $urandom, $urandom, 1'b1, 1'b0);
        run_os(4, 16, 2, 3, 32'h100, 32'h200, 32'h300, 1'b0, 1'b0);
        run_os(3, 5, 2, 3, 32'hFFFF_FFFD, 32'h55, 32'hFFFF_FFFE, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++)
            run_os($urandom_range(16, 1), $urandom_range(16, 1), $urandom_range(6, 1),
                   $urandom_range(3, 1), $urandom, $urandom, $urandom, 1'b0, 1'b0);
        run_intra(5, 7, $urandom, $urandom, $urandom);
        run_intra($urandom_range(16, 1), $urandom_range(16, 1), $urandom, $urandom, $urandom);

        for (int c = 0; c < 7; c++) begin
            cfg(bad[c][1], bad[c][2], bad[c][0], bad[c][3], 32'h10, 32'h20, 32'h30);
            bus_wr(R_CTRL, (c % 2 == 0) ? 32'd1 : 32'd2);
            check_val($sformatf("rej_irq%0d", c), 32'(ctl_obs), 32'(C_IRQ));
            bus_rd(R_STAT, d);
            check_val($sformatf("rej_status%0d", c), d, 32'd4);
            check_val($sformatf("rej_idle%0d", c), 32'(ctl_obs), 32'(C_SAR));
            bus_wr(R_CTRL, 32'h7);
            bus_rd(R_STAT, d);
            check_val($sformatf("err_clear%0d", c), d, 32'd0);
        end

        run_os(8, 8, 4, 2, 32'h40, 32'h80, 32'hC0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
